// File: rtl/regfile_scoreboard.sv
// 2-read/1-write integer register file with per-register busy scoreboard,
// write-to-read bypass and a decode-hold hazard output.
module regfile_scoreboard #(
  parameter int unsigned  XLEN      = 32,
  parameter int unsigned  NREGS     = 32,
  parameter bit           HARD_ZERO = 1'b1,
  parameter bit           BYPASS    = 1'b1,
  localparam int unsigned AW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rd_valid,
  output logic            hazard,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic            wr_ok, rsv_ok, rd_ok;
  logic            byp1, byp2, zero1, zero2, busy1, busy2;
  logic [XLEN-1:0] val1, val2;

  always_comb begin
    wr_ok  = wr_en && !(HARD_ZERO && (wr_addr == '0));
    rsv_ok = rsv_en && !(HARD_ZERO && (rsv_addr == '0));

    byp1  = BYPASS && wr_en && (wr_addr == rs1_addr);
    byp2  = BYPASS && wr_en && (wr_addr == rs2_addr);
    zero1 = HARD_ZERO && (rs1_addr == '0);
    zero2 = HARD_ZERO && (rs2_addr == '0);

    // A writeback landing this cycle satisfies the dependency when bypassing.
    busy1 = busy_q[rs1_addr] && !byp1 && !zero1;
    busy2 = busy_q[rs2_addr] && !byp2 && !zero2;

    val1 = zero1 ? '0 : (byp1 ? wr_data : regs_q[rs1_addr]);
    val2 = zero2 ? '0 : (byp2 ? wr_data : regs_q[rs2_addr]);

    hazard = rd_en && (busy1 || busy2);
    rd_ok  = rd_en && !hazard;
  end

  // Reservation is applied after the clear so a same-edge reissue stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wr_addr]  = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      busy_q   <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok) regs_q[wr_addr] <= wr_data;
      busy_q   <= busy_d;
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rs1_data <= val1;
        rs2_data <= val2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default build, a BYPASS=0 build sharing
// its stimulus, and a 16x64 build checked against a small reference model.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Default build and BYPASS=0 build, driven by the same inputs.
  logic        reset, rd_en, rsv_en, wr_en;
  logic [4:0]  rs1_addr, rs2_addr, rsv_addr, wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic        rd_valid, hazard, nb_rd_valid, nb_hazard;

  // 16-entry, 64-bit build.
  logic        w_reset, w_rd_en, w_rsv_en, w_wr_en;
  logic [3:0]  w_rs1_addr, w_rs2_addr, w_rsv_addr, w_wr_addr;
  logic [63:0] w_wr_data, w_rs1_data, w_rs2_data;
  logic        w_rd_valid, w_hazard;

  regfile_scoreboard u_dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_valid(rd_valid), .hazard(hazard),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  regfile_scoreboard #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data), .rd_valid(nb_rd_valid),
    .hazard(nb_hazard), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  regfile_scoreboard #(.XLEN(64), .NREGS(16)) u_wide (
    .clk(clk), .reset(w_reset), .rd_en(w_rd_en), .rs1_addr(w_rs1_addr),
    .rs2_addr(w_rs2_addr), .rs1_data(w_rs1_data), .rs2_data(w_rs2_data),
    .rd_valid(w_rd_valid), .hazard(w_hazard), .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Reset asserted together with read, write and reserve: reset must win.
    reset = 1'b1; rd_en = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd31;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_00FF;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    step();
    n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rd_valid);
    else n_pass++;
    n_total++; if (rs1_data !== 32'h0) $display("FAIL reset_rs1 got %h exp 0", rs1_data);
    else n_pass++;
    n_total++; if (rs2_data !== 32'h0) $display("FAIL reset_rs2 got %h exp 0", rs2_data);
    else n_pass++;
    reset = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    n_total++; if (hazard !== 1'b0) $display("FAIL t1_hazard got %b exp 0", hazard);
    else n_pass++;
    step();
    n_total++; if (rd_valid !== 1'b1) $display("FAIL t1_valid got %b exp 1", rd_valid);
    else n_pass++;
    n_total++; if (rs1_data !== 32'h0) $display("FAIL t1_rs1_x5 got %h exp 0", rs1_data);
    else n_pass++;
    n_total++; if (rs2_data !== 32'h0) $display("FAIL t1_rs2_x31 got %h exp 0", rs2_data);
    else n_pass++;
    // x6 reservation during reset must have been dropped.
    rs1_addr = 5'd6;
    #1;
    n_total++; if (hazard !== 1'b0) $display("FAIL t1_rsv_in_reset got %b exp 0", hazard);
    else n_pass++;
    step();
    rd_en = 1'b0;
    step();
    n_total++; if (rd_valid !== 1'b0) $display("FAIL t1_valid_drop got %b exp 0", rd_valid);
    else n_pass++;
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd0;
    step();
    n_total++; if (rs1_data !== 32'hDEAD_BEEF) $display("FAIL t2_rs1_x3 got %h exp deadbeef", rs1_data);
    else n_pass++;
    n_total++; if (rs2_data !== 32'h0) $display("FAIL t2_rs2_x0 got %h exp 0", rs2_data);
    else n_pass++;
    n_total++; if (rd_valid !== 1'b1) $display("FAIL t2_valid got %b exp 1", rd_valid);
    else n_pass++;
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd3;
    step();
    n_total++; if (rs1_data !== 32'h0) $display("FAIL t2_x0_write got %h exp 0", rs1_data);
    else n_pass++;
    n_total++; if (rs2_data !== 32'hDEAD_BEEF) $display("FAIL t2_rs2_x3 got %h exp deadbeef", rs2_data);
    else n_pass++;
    // Same-cycle bypass, and a same-cycle write to x0 must still read 0.
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE_0001; rs1_addr = 5'd10; rs2_addr = 5'd10;
    step();
    n_total++; if (rs1_data !== 32'hCAFE_0001) $display("FAIL t2_bypass1 got %h exp cafe0001", rs1_data);
    else n_pass++;
    n_total++; if (rs2_data !== 32'hCAFE_0001) $display("FAIL t2_bypass2 got %h exp cafe0001", rs2_data);
    else n_pass++;
    wr_addr = 5'd0; wr_data = 32'h5555_5555; rs1_addr = 5'd0;
    step();
    n_total++; if (rs1_data !== 32'h0) $display("FAIL t2_x0_bypass got %h exp 0", rs1_data);
    else n_pass++;
    wr_en = 1'b0; rd_en = 1'b0;
    step();
  endtask

  task automatic test_hazard();
    rsv_en = 1'b1; rsv_addr = 5'd7;
    step();
    rsv_en = 1'b0; rd_en = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd7;
    #1;
    n_total++; if (hazard !== 1'b1) $display("FAIL t3_hazard got %b exp 1", hazard);
    else n_pass++;
    n_total++; if (nb_hazard !== 1'b1) $display("FAIL t4_hazard got %b exp 1", nb_hazard);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++; if (rd_valid !== 1'b0) $display("FAIL t3_hold_valid got %b exp 0", rd_valid);
      else n_pass++;
      n_total++; if (hazard !== 1'b1) $display("FAIL t3_hold_hazard got %b exp 1", hazard);
      else n_pass++;
    end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0055;
    #1;
    n_total++; if (hazard !== 1'b0) $display("FAIL t3_wb_hazard got %b exp 0", hazard);
    else n_pass++;
    n_total++; if (nb_hazard !== 1'b1) $display("FAIL t4_wb_hazard got %b exp 1", nb_hazard);
    else n_pass++;
    step();
    wr_en = 1'b0;
    n_total++; if (rd_valid !== 1'b1) $display("FAIL t3_valid got %b exp 1", rd_valid);
    else n_pass++;
    n_total++; if (rs2_data !== 32'h0000_0055) $display("FAIL t3_rs2 got %h exp 55", rs2_data);
    else n_pass++;
    n_total++; if (nb_rd_valid !== 1'b0) $display("FAIL t4_wb_valid got %b exp 0", nb_rd_valid);
    else n_pass++;
    #1;
    n_total++; if (nb_hazard !== 1'b0) $display("FAIL t4_after_hazard got %b exp 0", nb_hazard);
    else n_pass++;
    step();
    n_total++; if (nb_rd_valid !== 1'b1) $display("FAIL t4_valid got %b exp 1", nb_rd_valid);
    else n_pass++;
    n_total++; if (nb_rs2_data !== 32'h0000_0055) $display("FAIL t4_rs2 got %h exp 55", nb_rs2_data);
    else n_pass++;
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_same_edge();
    rsv_en = 1'b1; rsv_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_00A5;
    step();
    rsv_en = 1'b0; wr_en = 1'b0; rd_en = 1'b1; rs1_addr = 5'd9; rs2_addr = 5'd0;
    #1;
    n_total++; if (hazard !== 1'b1) $display("FAIL t5_hazard got %b exp 1", hazard);
    else n_pass++;
    step();
    n_total++; if (rd_valid !== 1'b0) $display("FAIL t5_valid got %b exp 0", rd_valid);
    else n_pass++;
    // Read data holds while no read is accepted.
    n_total++; if (rs2_data !== 32'h0000_0055) $display("FAIL t5_hold got %h exp 55", rs2_data);
    else n_pass++;
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_hazard();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    step();
    rsv_en = 1'b0; rd_en = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd9;
    #1;
    n_total++; if (hazard !== 1'b1) $display("FAIL t6_hazard got %b exp 1", hazard);
    else n_pass++;
    reset = 1'b1;
    step();
    n_total++; if (rd_valid !== 1'b0) $display("FAIL t6_rst_valid got %b exp 0", rd_valid);
    else n_pass++;
    n_total++; if (rs2_data !== 32'h0) $display("FAIL t6_rst_rs2 got %h exp 0", rs2_data);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (hazard !== 1'b0) $display("FAIL t6_post_hazard got %b exp 0", hazard);
    else n_pass++;
    step();
    n_total++; if (rd_valid !== 1'b1) $display("FAIL t6_valid got %b exp 1", rd_valid);
    else n_pass++;
    n_total++; if (rs1_data !== 32'h0) $display("FAIL t6_rs1_x4 got %h exp 0", rs1_data);
    else n_pass++;
    n_total++; if (rs2_data !== 32'h0) $display("FAIL t6_rs2_x9 got %h exp 0", rs2_data);
    else n_pass++;
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_wide_random();
    logic [63:0] model [16];
    logic [63:0] exp1, exp2;
    logic        exp_v;
    for (int i = 0; i < 16; i++) model[i] = 64'h0;
    exp1 = 64'h0; exp2 = 64'h0;
    w_reset = 1'b0;
    for (int n = 0; n < 48; n++) begin
      w_wr_en    = 1'($urandom_range(0, 1));
      w_wr_addr  = 4'($urandom_range(0, 15));
      w_wr_data  = {$urandom, $urandom};
      w_rd_en    = 1'($urandom_range(0, 3) != 0);
      w_rs1_addr = (n % 4 == 0) ? w_wr_addr : 4'($urandom_range(0, 15));
      w_rs2_addr = (n % 5 == 0) ? w_wr_addr : 4'($urandom_range(0, 15));
      exp_v = w_rd_en;
      if (w_rd_en) begin
        exp1 = (w_rs1_addr == 4'd0) ? 64'h0 :
               (w_wr_en && w_wr_addr == w_rs1_addr) ? w_wr_data : model[w_rs1_addr];
        exp2 = (w_rs2_addr == 4'd0) ? 64'h0 :
               (w_wr_en && w_wr_addr == w_rs2_addr) ? w_wr_data : model[w_rs2_addr];
      end
      #1;
      n_total++; if (w_hazard !== 1'b0) $display("FAIL t6w_hazard[%0d] got %b exp 0", n, w_hazard);
      else n_pass++;
      step();
      if (w_wr_en && w_wr_addr != 4'd0) model[w_wr_addr] = w_wr_data;
      n_total++; if (w_rd_valid !== exp_v) $display("FAIL t6w_valid[%0d] got %b exp %b", n, w_rd_valid, exp_v);
      else n_pass++;
      n_total++; if (w_rs1_data !== exp1) $display("FAIL t6w_rs1[%0d] got %h exp %h", n, w_rs1_data, exp1);
      else n_pass++;
      n_total++; if (w_rs2_data !== exp2) $display("FAIL t6w_rs2[%0d] got %h exp %h", n, w_rs2_data, exp2);
      else n_pass++;
    end
    w_wr_en = 1'b0; w_rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b0; rsv_en = 1'b0; wr_en = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; rsv_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'h0;
    w_reset = 1'b1; w_rd_en = 1'b0; w_rsv_en = 1'b0; w_wr_en = 1'b0;
    w_rs1_addr = 4'd0; w_rs2_addr = 4'd0; w_rsv_addr = 4'd0; w_wr_addr = 4'd0;
    w_wr_data = 64'h0;
    step();
    test_reset();
    test_write_read();
    test_hazard();
    test_same_edge();
    test_reset_mid_hazard();
    test_wide_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
